next_pc_predictor: RTL and testbench
====================================

Name: next_pc_predictor

Overview:
Parametrised successor to the current next-PC select logic. Owns the fetch PC register and predicts the next fetch address in IF using a direct-mapped BTB plus a bimodal table of 2-bit saturating counters. Accepts branch/jump resolution from EX, trains both tables, and redirects with a pipeline flush on mispredict. Sits between the IF PC path and the EX branch unit and replaces the fixed "predict not-taken, correct at EX with -8" scheme.

Parameters:
XLEN, 32, data/address width (`CPU_WIDTH` in defines.v)
BHT_ENTRIES, 64, counter table entries, power of two, >=4
BTB_ENTRIES, 16, target buffer entries, power of two, >=2, <= BHT_ENTRIES
RESET_PC, `RESET_PC_VALUE, PC value after reset
CTR_INIT, 2'b01, counter reset value (weakly not-taken)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
ena  input  1  fetch enable; 0 = stall, hold PC
pc_o  output  XLEN  current fetch PC
pred_taken_o  output  1  prediction for instruction at pc_o, piped to EX by the pipeline
pred_target_o  output  XLEN  predicted target for pc_o, piped to EX
ex_valid_i  input  1  EX stage holds a valid instruction
ex_pc_i  input  XLEN  PC of EX instruction
ex_is_branch_i  input  1  EX instruction is conditional branch (B-type)
ex_is_jump_i  input  1  EX instruction is jal/jalr
ex_taken_i  input  1  actual outcome (1 for jumps)
ex_target_i  input  XLEN  actual target, already word-aligned (jalr LSBs cleared)
ex_pred_taken_i  input  1  prediction made for this instruction at fetch
ex_pred_target_i  input  XLEN  predicted target made at fetch
flush_o  output  1  kill IF/ID and ID/EX contents this cycle

Behaviour:
- Reset (rst=1 at edge): pc_o=RESET_PC; all BTB valid bits=0; all counters=CTR_INIT. pred_taken_o=0 while BTB empty. flush_o=0 during reset cycle regardless of inputs.
- Indexing: BHT index = pc[log2(BHT_ENTRIES)+1:2]; BTB index = pc[log2(BTB_ENTRIES)+1:2]; BTB tag = remaining upper PC bits [XLEN-1:log2(BTB_ENTRIES)+2]. BTB entry = {valid, tag, target, is_jump}.
- Prediction (combinational from pc_o): hit = valid && tag match. pred_taken_o = hit && (is_jump || ctr[1]). pred_target_o = hit ? entry.target : pc_o+4.
- Mispredict (combinational): mp = ex_valid_i && ( ((ex_is_branch_i||ex_is_jump_i) && (ex_taken_i!=ex_pred_taken_i || (ex_taken_i && ex_target_i!=ex_pred_target_i))) || (!ex_is_branch_i && !ex_is_jump_i && ex_pred_taken_i) ). Last term covers BTB alias on a non-control instruction.
- flush_o = mp && !rst, same cycle; fixed 1-cycle redirect latency.
- Redirect target = (ex_is_branch_i||ex_is_jump_i) && ex_taken_i ? ex_target_i : ex_pc_i+4.
- Next PC priority at each edge: rst -> RESET_PC; mp -> redirect target (overrides ena=0); !ena -> hold; pred_taken_o -> pred_target_o; else pc_o+4. Adds wrap modulo 2^XLEN.
- Training (edge, ex_valid_i && !rst):
  - branch: counter[ex_pc] saturating +1 if taken, -1 if not; 2'b11 stays on taken, 2'b00 stays on not-taken.
  - branch or jump with ex_taken_i=1: write BTB entry {1, tag(ex_pc), ex_target_i, ex_is_jump_i}, direct-mapped replace.
  - non-control instruction with ex_pred_taken_i=1: clear valid of its BTB entry only if tag matches.
  - Training happens whether or not ena is high.
- Same-cycle read/write same index: fetch reads pre-update contents; new contents visible next cycle.
- No internal state other than PC register, BTB, and counters; no FSM beyond saturating counters.

Decomposition:
- defines.v: add BP_CTR_WIDTH (2), strongly/weakly taken/not-taken encodings, RESET_PC_VALUE reused; opcode defines stay where they are.
- One sub-module: bp_btb (direct-mapped tag/target/valid array with one combinational read port, one write port, one invalidate port). Counter table and PC register stay in the top module.

Test Plan:
- Reset with rst=1 two cycles, then ena=1 -> pc_o=RESET_PC, then RESET_PC+4, +8; pred_taken_o=0, flush_o=0 throughout.
- Backward branch at 0x100 to 0x0F0 resolved taken 3 times -> first resolve: flush_o=1, pc_o=0x0F0 next cycle; counter 01->10->11->11; fourth fetch of 0x100 gives pred_taken_o=1, pred_target_o=0x0F0, no flush on resolve.
- Trained branch (counter 11) resolved not-taken -> flush_o=1, pc_o=0x104 next cycle, counter 10, still predicted taken on next fetch; second not-taken -> 01, predicted not-taken.
- jalr at 0x200, target 0x300 then 0x400 -> second resolve: target mismatch, flush_o=1, pc_o=0x400, BTB target updated to 0x400.
- Alias: BTB holds entry for 0x100, non-control instruction with same tag/index predicted taken -> flush_o=1, pc_o=ex_pc_i+4, entry invalidated (next fetch pred_taken_o=0).
- Mispredict with ena=0 in same cycle -> redirect still taken; rst=1 in same cycle as mp -> pc_o=RESET_PC, flush_o=0, no table update.

Source files
------------

// File: rtl/next_pc_predictor_pkg.sv
// Shared constants and helpers for the fetch-PC predictor: counter encodings,
// reset PC value and the saturating counter update.
package next_pc_predictor_pkg;

    localparam int unsigned BP_CTR_WIDTH = 2;

    typedef enum logic [BP_CTR_WIDTH-1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } bp_ctr_e;

    localparam logic [31:0] RESET_PC_VALUE = 32'h0000_0000;

    // Saturating 2-bit update: taken counts up to strongly-taken, not-taken down to strongly-not-taken.
    function automatic logic [BP_CTR_WIDTH-1:0] ctr_next(
        input logic [BP_CTR_WIDTH-1:0] ctr,
        input logic                    taken
    );
        if (taken) begin
            return (ctr == CTR_ST) ? ctr : ctr + BP_CTR_WIDTH'(1);
        end
        return (ctr == CTR_SNT) ? ctr : ctr - BP_CTR_WIDTH'(1);
    endfunction

endpackage

// File: rtl/next_pc_predictor_btb.sv
// Direct-mapped branch target buffer: one combinational read port for fetch,
// one write port and one tag-checked invalidate port for EX training.
module bp_btb
    import next_pc_predictor_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] rd_pc,
    output logic            rd_hit,
    output logic [XLEN-1:0] rd_target,
    output logic            rd_is_jump,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wr_pc,
    input  logic [XLEN-1:0] wr_target,
    input  logic            wr_is_jump,
    input  logic            inv_en,
    input  logic [XLEN-1:0] inv_pc
);

    localparam int unsigned IW = $clog2(ENTRIES);
    localparam int unsigned TW = XLEN - IW - 2;

    logic [ENTRIES-1:0] valid;
    logic [ENTRIES-1:0] is_jump;
    logic [TW-1:0]      tag    [ENTRIES];
    logic [XLEN-1:0]    target [ENTRIES];

    logic [IW-1:0] rd_idx, wr_idx, inv_idx;
    logic [TW-1:0] rd_tag, wr_tag, inv_tag;
    logic          unused_pc_lsbs;

    assign rd_idx  = rd_pc[IW+1:2];
    assign wr_idx  = wr_pc[IW+1:2];
    assign inv_idx = inv_pc[IW+1:2];
    assign rd_tag  = rd_pc[XLEN-1:IW+2];
    assign wr_tag  = wr_pc[XLEN-1:IW+2];
    assign inv_tag = inv_pc[XLEN-1:IW+2];
    assign unused_pc_lsbs = ^{rd_pc[1:0], wr_pc[1:0], inv_pc[1:0]};

    assign rd_hit     = valid[rd_idx] && (tag[rd_idx] == rd_tag);
    assign rd_target  = target[rd_idx];
    assign rd_is_jump = is_jump[rd_idx];

    // Only valid bits need reset; payload is qualified by valid on read.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end else if (inv_en && (tag[inv_idx] == inv_tag)) begin
            valid[inv_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag[wr_idx]     <= wr_tag;
            target[wr_idx]  <= wr_target;
            is_jump[wr_idx] <= wr_is_jump;
        end
    end

endmodule

// File: rtl/next_pc_predictor.sv
// Fetch PC register with BTB + bimodal next-PC prediction, trained from EX
// resolution, with same-cycle flush and redirect on mispredict.
module next_pc_predictor
    import next_pc_predictor_pkg::*;
#(
    parameter int unsigned                XLEN        = 32,
    parameter int unsigned                BHT_ENTRIES = 64,
    parameter int unsigned                BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0]            RESET_PC    = XLEN'(RESET_PC_VALUE),
    parameter logic [BP_CTR_WIDTH-1:0]    CTR_INIT    = CTR_WNT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    output logic [XLEN-1:0] pc_o,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    input  logic            ex_valid_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic            ex_is_branch_i,
    input  logic            ex_is_jump_i,
    input  logic            ex_taken_i,
    input  logic [XLEN-1:0] ex_target_i,
    input  logic            ex_pred_taken_i,
    input  logic [XLEN-1:0] ex_pred_target_i,
    output logic            flush_o
);

    localparam int unsigned BW = $clog2(BHT_ENTRIES);

    logic [BP_CTR_WIDTH-1:0] ctr [BHT_ENTRIES];
    logic [BW-1:0]           fetch_idx, ex_idx;

    logic            btb_hit, btb_is_jump;
    logic [XLEN-1:0] btb_target;
    logic            btb_wr, btb_inv;

    logic            is_ctl, mp;
    logic [XLEN-1:0] seq_pc, redirect, pc_next;

    assign fetch_idx = pc_o[BW+1:2];
    assign ex_idx    = ex_pc_i[BW+1:2];
    assign seq_pc    = pc_o + XLEN'(4);
    assign is_ctl    = ex_is_branch_i || ex_is_jump_i;
    assign btb_wr    = !rst && ex_valid_i && is_ctl && ex_taken_i;
    assign btb_inv   = !rst && ex_valid_i && !is_ctl && ex_pred_taken_i;

    bp_btb #(
        .XLEN    (XLEN),
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk        (clk),
        .rst        (rst),
        .rd_pc      (pc_o),
        .rd_hit     (btb_hit),
        .rd_target  (btb_target),
        .rd_is_jump (btb_is_jump),
        .wr_en      (btb_wr),
        .wr_pc      (ex_pc_i),
        .wr_target  (ex_target_i),
        .wr_is_jump (ex_is_jump_i),
        .inv_en     (btb_inv),
        .inv_pc     (ex_pc_i)
    );

    // Prediction, mispredict detection and next-PC priority.
    always_comb begin
        pred_taken_o  = btb_hit && (btb_is_jump || ctr[fetch_idx][1]);
        pred_target_o = btb_hit ? btb_target : seq_pc;

        mp = ex_valid_i &&
             ((is_ctl && ((ex_taken_i != ex_pred_taken_i) ||
                          (ex_taken_i && (ex_target_i != ex_pred_target_i)))) ||
              (!is_ctl && ex_pred_taken_i));
        flush_o  = mp && !rst;
        redirect = (is_ctl && ex_taken_i) ? ex_target_i : ex_pc_i + XLEN'(4);

        pc_next = seq_pc;
        if (mp) begin
            pc_next = redirect;
        end else if (!ena) begin
            pc_next = pc_o;
        end else if (pred_taken_o) begin
            pc_next = pred_target_o;
        end
    end

    // PC register and bimodal counters; training ignores ena.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_o <= RESET_PC;
            for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
                ctr[i] <= CTR_INIT;
            end
        end else begin
            pc_o <= pc_next;
            if (ex_valid_i && ex_is_branch_i) begin
                ctr[ex_idx] <= ctr_next(ctr[ex_idx], ex_taken_i);
            end
        end
    end

endmodule

// File: tb/tb_next_pc_predictor.sv
// Self-checking bench: directed scenarios then randomized EX traffic, checked
// every cycle against a behavioural table model of the predictor.
module tb_next_pc_predictor;

    localparam logic [31:0] RP = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        rst, ena;
    logic [31:0] pc, pred_target;
    logic        pred_taken, flush;
    logic        ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, ex_pred_target;

    next_pc_predictor #(
        .XLEN        (32),
        .BHT_ENTRIES (64),
        .BTB_ENTRIES (16),
        .RESET_PC    (RP),
        .CTR_INIT    (2'b01)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .ena              (ena),
        .pc_o             (pc),
        .pred_taken_o     (pred_taken),
        .pred_target_o    (pred_target),
        .ex_valid_i       (ex_valid),
        .ex_pc_i          (ex_pc),
        .ex_is_branch_i   (ex_is_branch),
        .ex_is_jump_i     (ex_is_jump),
        .ex_taken_i       (ex_taken),
        .ex_target_i      (ex_target),
        .ex_pred_taken_i  (ex_pred_taken),
        .ex_pred_target_i (ex_pred_target),
        .flush_o          (flush)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    bit known  = 0;

    // Model: counters 0..3, BTB entries remember the full owner PC.
    int          m_ctr [64];
    bit          m_bv  [16];
    bit          m_bj  [16];
    logic [31:0] m_bpc [16];
    logic [31:0] m_btgt[16];
    logic [31:0] m_pc;

    function automatic int btb_slot(input logic [31:0] a);
        return int'((a / 4) % 16);
    endfunction

    function automatic int bht_slot(input logic [31:0] a);
        return int'((a / 4) % 64);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        int s = btb_slot(a);
        return m_bv[s] && ((m_bpc[s] / 64) == (a / 64));
    endfunction

    function automatic bit m_ptaken(input logic [31:0] a);
        return m_hit(a) && (m_bj[btb_slot(a)] || m_ctr[bht_slot(a)] >= 2);
    endfunction

    function automatic logic [31:0] m_ptarget(input logic [31:0] a);
        return m_hit(a) ? m_btgt[btb_slot(a)] : a + 32'd4;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic ex_clear();
        ex_valid = 0; ex_pc = '0; ex_is_branch = 0; ex_is_jump = 0; ex_taken = 0;
        ex_target = '0; ex_pred_taken = 0; ex_pred_target = '0;
    endtask

    task automatic ex_set(input logic [31:0] a, input bit br, input bit jmp, input bit tk,
                          input logic [31:0] tg, input bit ptk, input logic [31:0] ptg);
        ex_valid = 1; ex_pc = a; ex_is_branch = br; ex_is_jump = jmp; ex_taken = tk;
        ex_target = tg; ex_pred_taken = ptk; ex_pred_target = ptg;
    endtask

    // Resolution carrying the prediction the model would have made for that PC.
    task automatic ex_resolve(input logic [31:0] a, input bit br, input bit jmp, input bit tk,
                              input logic [31:0] tg);
        ex_set(a, br, jmp, tk, tg, m_ptaken(a), m_ptarget(a));
    endtask

    // One cycle: check current outputs, cross the edge, advance the model.
    task automatic tick();
        bit ctl, mp, ptk;
        logic [31:0] ptg, nxt;
        int s;
        #1;
        ctl = ex_is_branch || ex_is_jump;
        mp  = ex_valid && ((ctl && ((ex_taken != ex_pred_taken) ||
                                    (ex_taken && ex_target != ex_pred_target))) ||
                           (!ctl && ex_pred_taken));
        check("flush", 32'(flush), 32'(mp && !rst));
        ptk = m_ptaken(m_pc);
        ptg = m_ptarget(m_pc);
        if (known) begin
            check("pc", pc, m_pc);
            check("pred_taken", 32'(pred_taken), 32'(ptk));
            check("pred_target", pred_target, ptg);
        end
        if (mp)          nxt = (ctl && ex_taken) ? ex_target : ex_pc + 32'd4;
        else if (!ena)   nxt = m_pc;
        else if (ptk)    nxt = ptg;
        else             nxt = m_pc + 32'd4;
        @(posedge clk);
        if (rst) begin
            known = 1;
            m_pc  = RP;
            for (int i = 0; i < 64; i++) m_ctr[i] = 1;
            for (int i = 0; i < 16; i++) m_bv[i] = 0;
        end else begin
            m_pc = nxt;
            if (ex_valid) begin
                if (ex_is_branch) begin
                    s = bht_slot(ex_pc);
                    m_ctr[s] = ex_taken ? ((m_ctr[s] == 3) ? 3 : m_ctr[s] + 1)
                                        : ((m_ctr[s] == 0) ? 0 : m_ctr[s] - 1);
                end
                s = btb_slot(ex_pc);
                if (ctl && ex_taken) begin
                    m_bv[s] = 1; m_bpc[s] = ex_pc; m_btgt[s] = ex_target; m_bj[s] = ex_is_jump;
                end else if (!ctl && ex_pred_taken && m_hit(ex_pc)) begin
                    m_bv[s] = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    // Steer fetch to a PC via a non-control mispredict at a-4 (redirect = a).
    task automatic goto_pc(input logic [31:0] a);
        ex_set(a - 32'd4, 0, 0, 0, 32'd0, 1, 32'd0);
        tick();
        ex_clear();
        check("goto_pc", pc, a);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, t;
        int kind;
        rst = 1; ena = 0;
        ex_set(32'h10, 0, 0, 0, 32'd0, 1, 32'd0);
        @(negedge clk);
        tick();
        tick();
        rst = 0; ena = 1;
        ex_clear();
        #1;
        check("rst_pc", pc, RP);
        check("rst_pred", 32'(pred_taken), 32'd0);
        tick();
        check("rst_pc4", pc, RP + 32'd4);
        tick();
        check("rst_pc8", pc, RP + 32'd8);
        tick();

        // Backward branch 0x100 -> 0x0F0 taken three times.
        goto_pc(32'h100);
        ex_resolve(32'h100, 1, 0, 1, 32'h0F0);
        #1 check("bwd1_flush", 32'(flush), 32'd1);
        tick();
        check("bwd1_pc", pc, 32'h0F0);
        ex_resolve(32'h100, 1, 0, 1, 32'h0F0);
        #1 check("bwd2_flush", 32'(flush), 32'd0);
        tick();
        ex_resolve(32'h100, 1, 0, 1, 32'h0F0);
        tick();
        ex_clear();
        goto_pc(32'h100);
        check("bwd_pred", 32'(pred_taken), 32'd1);
        check("bwd_tgt", pred_target, 32'h0F0);
        tick();

        // Strongly-taken branch resolved not-taken twice.
        ex_resolve(32'h100, 1, 0, 0, 32'h0F0);
        #1 check("nt1_flush", 32'(flush), 32'd1);
        tick();
        check("nt1_pc", pc, 32'h104);
        goto_pc(32'h100);
        check("nt1_pred", 32'(pred_taken), 32'd1);
        ex_resolve(32'h100, 1, 0, 0, 32'h0F0);
        tick();
        ex_clear();
        goto_pc(32'h100);
        check("nt2_pred", 32'(pred_taken), 32'd0);
        check("nt2_tgt", pred_target, 32'h0F0);
        tick();

        // Non-control instruction aliasing the 0x100 entry.
        ex_set(32'h100, 0, 0, 0, 32'd0, 1, 32'h0F0);
        #1 check("alias_flush", 32'(flush), 32'd1);
        tick();
        ex_clear();
        check("alias_pc", pc, 32'h104);
        goto_pc(32'h100);
        check("alias_pred", 32'(pred_taken), 32'd0);
        check("alias_tgt", pred_target, 32'h104);
        tick();

        // jalr at 0x200 changing target 0x300 -> 0x400.
        ex_resolve(32'h200, 0, 1, 1, 32'h300);
        tick();
        check("jalr1_pc", pc, 32'h300);
        ex_resolve(32'h200, 0, 1, 1, 32'h400);
        #1 check("jalr2_flush", 32'(flush), 32'd1);
        tick();
        ex_clear();
        check("jalr2_pc", pc, 32'h400);
        goto_pc(32'h200);
        check("jalr_pred", 32'(pred_taken), 32'd1);
        check("jalr_tgt", pred_target, 32'h400);
        tick();

        // Redirect overrides stall; stall alone holds.
        ena = 0;
        ex_set(32'h500, 0, 0, 0, 32'd0, 1, 32'd0);
        tick();
        ex_clear();
        check("stall_redir", pc, 32'h504);
        tick();
        check("stall_hold", pc, 32'h504);
        ena = 1;

        // Reset wins over a simultaneous mispredict.
        rst = 1;
        ex_resolve(32'h600, 1, 0, 1, 32'h700);
        #1 check("rst_mp_flush", 32'(flush), 32'd0);
        tick();
        rst = 0;
        ex_clear();
        check("rst_mp_pc", pc, RP);
        tick();

        // Randomized traffic over a small PC pool with aliasing tags.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            ena = ($urandom_range(0, 3) != 0);
            a = 32'h1000 + 32'($urandom_range(0, 31)) * 32'd4;
            if ($urandom_range(0, 3) == 0) a = a + 32'h400;
            if ($urandom_range(0, 3) == 0) a = m_pc;
            t = 32'h1000 + 32'($urandom_range(0, 63)) * 32'd4;
            if ($urandom_range(0, 7) == 0) t = $urandom & 32'hFFFF_FFFC;
            kind = int'($urandom_range(0, 2));
            if ($urandom_range(0, 2) == 0) begin
                ex_clear();
            end else if ($urandom_range(0, 1) == 0) begin
                ex_resolve(a, kind == 0, kind == 1, (kind == 1) || ($urandom_range(0, 1) == 1), t);
            end else begin
                ex_set(a, kind == 0, kind == 1, (kind == 1) || ($urandom_range(0, 1) == 1), t,
                       1'($urandom_range(0, 1)), m_ptarget(a));
            end
            tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
